// File: rtl/neuron_accumulator.sv
// Accumulates N_INPUTS signed-magnitude products plus a bias into one saturated
// signed-magnitude neuron sum. Define NEURON_RELU_EN to clamp negative results to zero.
module neuron_accumulator #(
   parameter int N_INPUTS = 16,
   parameter int DATA_W   = 32,
   parameter int FRAC_W   = 17
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [DATA_W-1:0] bias,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              busy,
   output logic              sat_flag
);

   localparam int ACC_W = DATA_W + $clog2(N_INPUTS) + 2;
   localparam int CNT_W = $clog2(N_INPUTS + 1);
   localparam int MAG_W = DATA_W - 1;
   localparam logic [ACC_W-1:0] MAG_MAX = {{(ACC_W-MAG_W){1'b0}}, {MAG_W{1'b1}}};

   if (N_INPUTS < 1) begin : g_bad_n
      $error("neuron_accumulator: N_INPUTS must be >= 1");
   end
   if (FRAC_W >= DATA_W) begin : g_bad_frac
      $error("neuron_accumulator: FRAC_W must be below DATA_W");
   end

   typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_FINISH, S_OUT} state_t;

   // Negative zero maps to 0 because -0 == 0 in two's complement.
   function automatic logic signed [ACC_W-1:0] sm_to_tc(input logic [DATA_W-1:0] w);
      logic signed [ACC_W-1:0] m;
      m = signed'({{(ACC_W-MAG_W){1'b0}}, w[MAG_W-1:0]});
      return w[DATA_W-1] ? -m : m;
   endfunction

   state_t                  state_q, state_d;
   logic signed [ACC_W-1:0] acc_q, acc_d;
   logic [CNT_W-1:0]        count_q, count_d;
   logic                    in_ready_q, in_ready_d;
   logic                    out_valid_q, out_valid_d;
   logic [DATA_W-1:0]       out_data_q, out_data_d;
   logic                    sat_q, sat_d;
   logic                    busy_q, busy_d;

   logic [ACC_W-1:0]        acc_abs;
   logic                    acc_neg;
   logic                    acc_over;
   logic [MAG_W-1:0]        res_mag;
   logic [DATA_W-1:0]       res_data;
   logic                    res_sat;

   always_comb begin
      acc_neg  = acc_q[ACC_W-1];
      acc_abs  = acc_neg ? unsigned'(-acc_q) : unsigned'(acc_q);
      acc_over = acc_abs > MAG_MAX;
      res_mag  = acc_over ? {MAG_W{1'b1}} : acc_abs[MAG_W-1:0];
`ifdef NEURON_RELU_EN
      res_data = acc_neg ? '0 : {1'b0, res_mag};
      res_sat  = acc_neg ? 1'b0 : acc_over;
`else
      // acc_neg implies a nonzero magnitude, so negative zero cannot appear.
      res_data = {acc_neg, res_mag};
      res_sat  = acc_over;
`endif
   end

   always_comb begin
      state_d     = state_q;
      acc_d       = acc_q;
      count_d     = count_q;
      in_ready_d  = in_ready_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      sat_d       = sat_q;
      busy_d      = busy_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               acc_d      = sm_to_tc(bias);
               count_d    = '0;
               state_d    = S_ACCUM;
               in_ready_d = 1'b1;
               busy_d     = 1'b1;
            end
         end
         S_ACCUM: begin
            if (in_valid) begin
               acc_d   = acc_q + sm_to_tc(in_data);
               count_d = count_q + CNT_W'(1);
               if (count_q == CNT_W'(N_INPUTS - 1)) begin
                  state_d    = S_FINISH;
                  in_ready_d = 1'b0;
               end
            end
         end
         S_FINISH: begin
            out_data_d  = res_data;
            sat_d       = res_sat;
            out_valid_d = 1'b1;
            state_d     = S_OUT;
         end
         S_OUT: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               busy_d      = 1'b0;
               state_d     = S_IDLE;
            end
         end
         default: begin
            state_d     = S_IDLE;
            in_ready_d  = 1'b0;
            out_valid_d = 1'b0;
            busy_d      = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         acc_q       <= '0;
         count_q     <= '0;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         sat_q       <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         count_q     <= count_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         sat_q       <= sat_d;
         busy_q      <= busy_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign sat_flag  = sat_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_neuron_accumulator.sv
// Bench for neuron_accumulator: a 4-input and a 16-input instance checked every cycle
// against a transaction-level sum model, plus literal expectations from worked examples.
module tb_neuron_accumulator;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start [2];
   logic        in_valid [2];
   logic        out_ready [2];
   logic        in_ready [2];
   logic        out_valid [2];
   logic        busy [2];
   logic        sat_flag [2];
   logic [31:0] bias [2];
   logic [31:0] in_data [2];
   logic [31:0] out_data [2];

   int n_vec = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   neuron_accumulator #(.N_INPUTS(4), .DATA_W(32), .FRAC_W(17)) dut4 (
      .clk(clk), .rst_n(rst_n), .start(start[0]), .bias(bias[0]),
      .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]),
      .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]),
      .busy(busy[0]), .sat_flag(sat_flag[0]));

   neuron_accumulator #(.N_INPUTS(16), .DATA_W(32), .FRAC_W(17)) dut16 (
      .clk(clk), .rst_n(rst_n), .start(start[1]), .bias(bias[1]),
      .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]),
      .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1]),
      .busy(busy[1]), .sat_flag(sat_flag[1]));

   function automatic int ni(input int k);
      return (k == 0) ? 4 : 16;
   endfunction

   function automatic longint sm2i(input logic [31:0] w);
      longint m;
      m = longint'(w[30:0]);
      return w[31] ? -m : m;
   endfunction

   // {sat, data} for a true sum, straight from the saturation and sign rules.
   function automatic logic [32:0] pack(input longint s);
      longint      a;
      logic        sat;
      logic [30:0] mag;
      a   = (s < 0) ? -s : s;
      sat = (a > 64'sd2147483647);
      mag = sat ? 31'h7FFFFFFF : a[30:0];
`ifdef NEURON_RELU_EN
      if (s < 0) return 33'd0;
      return {sat, 1'b0, mag};
`else
      return {sat, (s < 0), mag};
`endif
   endfunction

   function automatic logic [31:0] rnd_word();
      logic [31:0] w;
      w = $urandom;
      if ($urandom_range(0, 3) != 0) w[30:24] = '0;
      return w;
   endfunction

   task automatic check(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s dut%0d @%0t: got %h expected %h", name, k, $time, act, exp);
      end
   endtask

   bit          m_busy [2];
   bit          m_fin [2];
   bit          m_outv [2];
   logic        m_sat [2];
   int          m_terms [2];
   longint      m_sum [2];
   logic [31:0] m_data [2];

   always @(posedge clk or negedge rst_n) begin
      for (int k = 0; k < 2; k++) begin
         if (!rst_n) begin
            m_busy[k]  <= 1'b0;
            m_fin[k]   <= 1'b0;
            m_outv[k]  <= 1'b0;
            m_terms[k] <= 0;
            m_sum[k]   <= 0;
         end else if (!m_busy[k]) begin
            if (start[k]) begin
               m_busy[k]  <= 1'b1;
               m_terms[k] <= 0;
               m_sum[k]   <= sm2i(bias[k]);
            end
         end else if (m_terms[k] < ni(k)) begin
            if (in_valid[k]) begin
               m_sum[k]   <= m_sum[k] + sm2i(in_data[k]);
               m_terms[k] <= m_terms[k] + 1;
               if (m_terms[k] == ni(k) - 1) m_fin[k] <= 1'b1;
            end
         end else if (m_fin[k]) begin
            m_fin[k]  <= 1'b0;
            m_outv[k] <= 1'b1;
            {m_sat[k], m_data[k]} <= pack(m_sum[k]);
         end else if (m_outv[k] && out_ready[k]) begin
            m_outv[k] <= 1'b0;
            m_busy[k] <= 1'b0;
         end
      end
   end

   always @(negedge clk) begin
      for (int k = 0; k < 2; k++) begin
         check("in_ready", k, 32'(in_ready[k]), 32'(m_busy[k] && m_terms[k] < ni(k)));
         check("busy", k, 32'(busy[k]), 32'(m_busy[k]));
         check("out_valid", k, 32'(out_valid[k]), 32'(m_outv[k]));
         if (m_outv[k]) begin
            check("out_data", k, out_data[k], m_data[k]);
            check("sat_flag", k, 32'(sat_flag[k]), 32'(m_sat[k]));
         end
         if (!rst_n) begin
            check("rst_out_data", k, out_data[k], 32'h0);
            check("rst_sat", k, 32'(sat_flag[k]), 32'h0);
         end
      end
   end

   task automatic check_zero(input int k);
      check("z_in_ready", k, 32'(in_ready[k]), 32'h0);
      check("z_out_valid", k, 32'(out_valid[k]), 32'h0);
      check("z_out_data", k, out_data[k], 32'h0);
      check("z_busy", k, 32'(busy[k]), 32'h0);
      check("z_sat", k, 32'(sat_flag[k]), 32'h0);
   endtask

   task automatic run_neuron(input int k, input logic [31:0] b, input logic [31:0] t [16],
                             input int gaps, input int hold, input bit use_lit,
                             input logic [31:0] lit_d, input logic lit_s);
      int i;
      int budget;
      @(posedge clk); #1;
      start[k] = 1'b1;
      bias[k]  = b;
      @(posedge clk); #1;
      start[k] = 1'b0;
      bias[k]  = $urandom;
      i = 0;
      budget = 0;
      while (i < ni(k) && budget < 200) begin
         in_valid[k] = (gaps == 0) || ($urandom_range(0, 2) != 0);
         in_data[k]  = in_valid[k] ? t[i] : $urandom;
         @(posedge clk); #1;
         if (in_valid[k]) i++;
         budget++;
      end
      check("term_budget", k, 32'(i), 32'(ni(k)));
      in_valid[k] = 1'($urandom_range(0, 1));
      in_data[k]  = $urandom;
      check("lat_t", k, 32'(out_valid[k]), 32'h0);
      @(posedge clk); #1;
      check("lat_t1", k, 32'(out_valid[k]), 32'h1);
      if (use_lit) begin
         check("lit_data", k, out_data[k], lit_d);
         check("lit_sat", k, 32'(sat_flag[k]), 32'(lit_s));
      end
      repeat (hold) begin
         start[k]    = 1'($urandom_range(0, 1));
         in_valid[k] = 1'($urandom_range(0, 1));
         in_data[k]  = $urandom;
         @(posedge clk); #1;
      end
      if (use_lit) check("lit_data_held", k, out_data[k], lit_d);
      out_ready[k] = 1'b1;
      start[k]     = 1'b1;
      @(posedge clk); #1;
      out_ready[k] = 1'b0;
      start[k]     = 1'b0;
      in_valid[k]  = 1'b0;
      check("start_in_out_ignored", k, 32'(busy[k]), 32'h0);
   endtask

   initial begin
      logic [31:0] tv [16];
      for (int k = 0; k < 2; k++) begin
         start[k] = 1'b0; in_valid[k] = 1'b0; out_ready[k] = 1'b0;
         bias[k] = '0; in_data[k] = '0;
      end
      repeat (2) @(posedge clk);
      #1;
      check_zero(0);
      check_zero(1);
      rst_n = 1'b1;

      for (int j = 0; j < 16; j++) tv[j] = 32'h00111458;
      run_neuron(0, 32'h0, tv, 0, 0, 1'b1, 32'h00445160, 1'b0);

      tv[0] = 32'h00020000; tv[1] = 32'h80020000; tv[2] = 32'h80000000; tv[3] = 32'h80020000;
      run_neuron(0, 32'h00020000, tv, 0, 2, 1'b1, 32'h00000000, 1'b0);

      for (int j = 0; j < 16; j++) tv[j] = 32'h80020000;
`ifdef NEURON_RELU_EN
      run_neuron(0, 32'h0, tv, 0, 1, 1'b1, 32'h00000000, 1'b0);
`else
      run_neuron(0, 32'h0, tv, 0, 1, 1'b1, 32'h80080000, 1'b0);
`endif

      for (int j = 0; j < 16; j++) tv[j] = 32'h7FFFFFFF;
      run_neuron(1, 32'h7FFFFFFF, tv, 0, 0, 1'b1, 32'h7FFFFFFF, 1'b1);
      for (int j = 0; j < 16; j++) tv[j] = 32'hFFFFFFFF;
`ifdef NEURON_RELU_EN
      run_neuron(1, 32'hFFFFFFFF, tv, 0, 0, 1'b1, 32'h00000000, 1'b0);
`else
      run_neuron(1, 32'hFFFFFFFF, tv, 0, 0, 1'b1, 32'hFFFFFFFF, 1'b1);
`endif

      tv[0] = 32'h00001000; tv[1] = 32'h80000800; tv[2] = 32'h00000400; tv[3] = 32'h00000200;
      run_neuron(0, 32'h00010000, tv, 1, 10, 1'b1, 32'h00010E00, 1'b0);

      // Abort a neuron after two accepted terms, then confirm a clean restart.
      @(posedge clk); #1;
      start[0] = 1'b1; bias[0] = 32'h00012345;
      @(posedge clk); #1;
      start[0] = 1'b0; in_valid[0] = 1'b1; in_data[0] = 32'h00300000;
      repeat (2) @(posedge clk);
      #1;
      in_valid[0] = 1'b0;
      check("pre_abort_busy", 0, 32'(busy[0]), 32'h1);
      #2 rst_n = 1'b0;
      #1;
      check_zero(0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      for (int j = 0; j < 16; j++) tv[j] = 32'h00020000;
      run_neuron(0, 32'h0, tv, 0, 0, 1'b1, 32'h00080000, 1'b0);

      for (int r = 0; r < 24; r++) begin
         int k;
         k = (r % 4 == 3) ? 1 : 0;
         for (int j = 0; j < 16; j++) tv[j] = rnd_word();
         run_neuron(k, rnd_word(), tv, 1, int'($urandom_range(0, 4)), 1'b0, 32'h0, 1'b0);
      end

      repeat (3) @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
